reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Per-register pending-write tracker for the 16-entry pipeline register file (4-bit register addresses, 32-bit data). The issue stage checks it before it accepts each instruction. Writeback and flush inform it when reserved destinations retire or are squashed. The block generates the decode-stage stall for read-after-write hazards and write-slot overflow. It also relies on the register file's negedge write to resolve same-cycle writeback without a stall.

## Interface
Parameters:
- CNT_W, 2, width of each per-register pending counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock; counters update on posedge.
- rst  input  1  reset, asynchronous, active-high.
- issue_valid  input  1  decode has an instruction to issue this cycle.
- issue_wb_en  input  1  the instruction writes a register.
- issue_dest  input  4  destination register.
- src1, src2  input  4  source registers.
- use_src2  input  1  src2 is actually read; when 0, src2 is ignored.
- wb_valid  input  1  writeback retires a register write this cycle. Same qualifier as the register file's writeBackEn.
- wb_dest  input  4  retiring destination.
- flush_valid  input  1  a squashed instruction releases its reservation.
- flush_dest  input  4  released destination.
- stall  output  1  combinational; 1 means decode must hold and not issue.
- issue_accept  output  1  combinational; issue_valid & ~stall.
- busy  output  16  bit r = (cnt[r] != 0), registered view.
- inflight  output  6  registered total of all counters.
- err  output  1  sticky underflow flag.

## Operation
- State: cnt[0..15], each CNT_W bits; inflight; err.
- Reset behaviour (asynchronous, immediate, independent of clk):
  - all cnt = 0, inflight = 0, err = 0, so busy = 0.
  - stall is then driven purely by the current inputs, which with cnt = 0 gives stall = 0.
- Effective pending for register r in the current cycle:
  - pend[r] = cnt[r] - (wb_valid & wb_dest==r) - (flush_valid & flush_dest==r), floored at 0.
  - Same-cycle writeback counts as resolved, because the register file writes on negedge and the value is readable before the next posedge.
- RAW hazard:
  - issue_valid & (pend[src1]!=0 | (use_src2 & pend[src2]!=0)).
  - Register 15 is treated like any other register.
- Overflow hazard: issue_valid & issue_wb_en & cnt[issue_dest] == max.
  - Uses the raw count, not pend, so a full counter stalls even if a writeback is retiring that register this cycle.
- stall = RAW hazard | overflow hazard; stall = 0 when issue_valid = 0.
- Counter update at posedge, per register r:
  - inc = issue_accept & issue_wb_en & issue_dest==r
  - dec = (wb_valid & wb_dest==r) + (flush_valid & flush_dest==r)
  - cnt[r] next = cnt[r] + inc - dec.
- Simultaneous events:
  - inc, wb and flush may all target the same register in one cycle; the net delta is applied in that single update.
  - wb_dest == flush_dest gives a decrement of 2.
- Underflow: if cnt[r] + inc < dec, then cnt[r] next = 0 and err is set. err stays set until rst.
- inflight next = sum of all next cnt values (maximum 16*3 = 48, fits in 6 bits).
- No other clear path exists. A full pipeline flush is expressed as one flush_valid per squashed writer.

## Timing
- Stall latency: 0 cycles; stall is a function of the registered counters and the current-cycle inputs.
- Reservation latency: an issue accepted in cycle N makes busy and the cnt increment visible from cycle N+1.
  - A dependent instruction in cycle N+1 stalls.
- Release latency:
  - A writeback in cycle M removes the hazard in cycle M itself, via pend.
  - busy clears at M+1.
- Flush is treated identically to writeback, both for pend and for the counter update.
- If rst asserts mid-operation, all state is dropped immediately. The next posedge after rst deasserts processes inputs normally.
- No multi-cycle state machine: each register's counter is a saturation-guarded up/down counter.
  - Issue is blocked at max, so a counter never wraps.
  - Underflow clamps the counter to 0 and sets err.

## Test plan
- Reset, then issue r3 (wb_en=1), then next cycle issue src1=3:
  - second issue stalls (stall=1, issue_accept=0); busy=0x0008; inflight=1.
  - With wb_valid, wb_dest=3 in that same cycle: stall=0 and the dependent issue is accepted.
- Issue r5 three times with no writeback:
  - cnt[5]=3, inflight=3.
  - A fourth issue to dest 5 stalls.
  - Same cycle with wb_dest=5: still stalls, because overflow uses the raw count.
  - Next cycle (cnt=2): the fourth issue is accepted.
- One cycle with an accepted issue to r7, wb_dest=7 and flush_dest=7, starting from cnt[7]=2:
  - cnt[7] next = 1; err stays 0.
- wb_valid with wb_dest=9 while cnt[9]=0:
  - err=1 and stays 1; cnt[9]=0; all other counters unchanged.
- use_src2=0 with src2 = a busy register:
  - no stall.
  - Same case with use_src2=1: stall=1.
- Reserve r1, r2 and r4 (inflight=3), then assert rst asynchronously between clock edges:
  - busy=0, inflight=0 and err=0 immediately, before the next edge.
  - After release, an issue reading r1 does not stall.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the 16-entry register file.
// Raises the decode stall on RAW hazards and per-register counter saturation.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_wb_en,
    input  logic [3:0]  issue_dest,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        use_src2,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dest,
    input  logic        flush_valid,
    input  logic [3:0]  flush_dest,
    output logic        stall,
    output logic        issue_accept,
    output logic [15:0] busy,
    output logic [5:0]  inflight,
    output logic        err
);

    localparam int EW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [16];
    logic [CNT_W-1:0] cnt_nxt [16];
    logic [1:0]       dec     [16];
    logic [15:0]      pend_nz;
    logic [15:0]      under;
    logic [5:0]       total_nxt;
    logic [EW-1:0]    sum;
    logic             inc;
    logic             raw_haz;
    logic             ovf_haz;

    // Same-cycle writeback or flush already resolves the value via negedge write
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            dec[r] = {1'b0, wb_valid && (wb_dest == 4'(r))}
                   + {1'b0, flush_valid && (flush_dest == 4'(r))};
            pend_nz[r] = EW'(cnt[r]) > EW'(dec[r]);
        end
    end

    assign raw_haz = issue_valid
                   && (pend_nz[src1] || (use_src2 && pend_nz[src2]));
    assign ovf_haz = issue_valid && issue_wb_en
                   && (cnt[issue_dest] == CNT_MAX);
    assign stall        = raw_haz || ovf_haz;
    assign issue_accept = issue_valid && !stall;

    always_comb begin
        sum       = '0;
        inc       = 1'b0;
        total_nxt = '0;
        under     = '0;
        for (int r = 0; r < 16; r++) begin
            inc = issue_accept && issue_wb_en && (issue_dest == 4'(r));
            sum = EW'(cnt[r]) + EW'(inc);
            if (sum < EW'(dec[r])) begin
                under[r]   = 1'b1;
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = CNT_W'(sum - EW'(dec[r]));
            end
            total_nxt = total_nxt + 6'(cnt_nxt[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '{default: '0};
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            inflight <= total_nxt;
            err      <= err || (|under);
        end
    end

    always_comb begin
        for (int r = 0; r < 16; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, reset corner case,
// and random traffic against a counting reference model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wb_en, use_src2;
    logic [3:0]  issue_dest, src1, src2;
    logic        wb_valid, flush_valid;
    logic [3:0]  wb_dest, flush_dest;
    logic        stall, issue_accept, err;
    logic [15:0] busy;
    logic [5:0]  inflight;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_dest(issue_dest), .src1(src1), .src2(src2),
        .use_src2(use_src2),
        .wb_valid(wb_valid), .wb_dest(wb_dest),
        .flush_valid(flush_valid), .flush_dest(flush_dest),
        .stall(stall), .issue_accept(issue_accept),
        .busy(busy), .inflight(inflight), .err(err)
    );

    typedef struct {
        logic       v, en;
        logic [3:0] d, s1, s2;
        logic       u2, wv;
        logic [3:0] wd;
        logic       fv;
        logic [3:0] fd;
        logic       st;
        logic [15:0] bsy;
        logic [5:0] inf;
        logic       er;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic en, input logic [3:0] d,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic u2, input logic wv, input logic [3:0] wd,
                         input logic fv, input logic [3:0] fd);
        issue_valid = v;  issue_wb_en = en; issue_dest = d;
        src1 = s1;        src2 = s2;        use_src2 = u2;
        wb_valid = wv;    wb_dest = wd;
        flush_valid = fv; flush_dest = fd;
    endtask

    function automatic vec_t mk(input logic v, input logic en, input logic [3:0] d,
                                input logic [3:0] s1, input logic [3:0] s2,
                                input logic u2, input logic wv, input logic [3:0] wd,
                                input logic fv, input logic [3:0] fd,
                                input logic st, input logic [15:0] bsy,
                                input logic [5:0] inf, input logic er);
        vec_t t;
        t.v = v; t.en = en; t.d = d; t.s1 = s1; t.s2 = s2; t.u2 = u2;
        t.wv = wv; t.wd = wd; t.fv = fv; t.fd = fd;
        t.st = st; t.bsy = bsy; t.inf = inf; t.er = er;
        return t;
    endfunction

    // Reference model: plain integer counts per register
    int  mcnt[16];
    bit  merr;

    function automatic int hits(input int r);
        return int'(wb_valid && wb_dest == 4'(r))
             + int'(flush_valid && flush_dest == 4'(r));
    endfunction

    function automatic bit model_stall();
        int p1, p2;
        if (!issue_valid) return 1'b0;
        p1 = mcnt[src1] - hits(src1);
        p2 = mcnt[src2] - hits(src2);
        if (p1 > 0) return 1'b1;
        if (use_src2 && p2 > 0) return 1'b1;
        if (issue_wb_en && mcnt[issue_dest] == 3) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit acc);
        int n;
        for (int r = 0; r < 16; r++) begin
            n = mcnt[r] - hits(r);
            if (acc && issue_wb_en && issue_dest == 4'(r)) n++;
            if (n < 0) begin
                n = 0;
                merr = 1'b1;
            end
            mcnt[r] = n;
        end
    endtask

    function automatic logic [15:0] mbusy();
        logic [15:0] b;
        for (int r = 0; r < 16; r++) b[r] = (mcnt[r] != 0);
        return b;
    endfunction

    function automatic int mtotal();
        int s = 0;
        for (int r = 0; r < 16; r++) s += mcnt[r];
        return s;
    endfunction

    initial begin
        bit acc;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset busy", busy, 16'h0);
        chk("reset inflight", inflight, 6'd0);
        chk("reset err", err, 1'b0);
        chk("reset stall", stall, 1'b0);

        //            v en d  s1 s2 u2 wv wd fv fd  st bsy      inf er
        tbl[0]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0008, 1, 0);
        tbl[1]  = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0,  1, 16'h0008, 1, 0);
        tbl[2]  = mk(1, 0, 0, 3, 0, 0, 1, 3, 0, 0,  0, 16'h0000, 0, 0);
        tbl[3]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0020, 1, 0);
        tbl[4]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0020, 2, 0);
        tbl[5]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0020, 3, 0);
        tbl[6]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 16'h0020, 3, 0);
        tbl[7]  = mk(1, 1, 5, 0, 0, 0, 1, 5, 0, 0,  1, 16'h0020, 2, 0);
        tbl[8]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0020, 3, 0);
        tbl[9]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 16'h00A0, 4, 0);
        tbl[10] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 16'h00A0, 5, 0);
        tbl[11] = mk(1, 1, 7, 0, 0, 0, 1, 7, 1, 7,  0, 16'h00A0, 4, 0);
        tbl[12] = mk(1, 0, 0, 0, 5, 0, 0, 0, 0, 0,  0, 16'h00A0, 4, 0);
        tbl[13] = mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 0,  1, 16'h00A0, 4, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0,  0, 16'h00A0, 4, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 16'h00A0, 4, 1);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].en, tbl[i].d, tbl[i].s1, tbl[i].s2,
                  tbl[i].u2, tbl[i].wv, tbl[i].wd, tbl[i].fv, tbl[i].fd);
            #1;
            chk($sformatf("vec%0d stall", i), stall, tbl[i].st);
            chk($sformatf("vec%0d accept", i), issue_accept,
                tbl[i].v & ~tbl[i].st);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d inflight", i), inflight, tbl[i].inf);
            chk($sformatf("vec%0d err", i), err, tbl[i].er);
        end

        // Asynchronous reset between edges drops all state at once
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 1, 4, 0, 0, 0, 1, 9, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rsv busy", busy, 16'h0016);
        chk("rsv inflight", inflight, 6'd3);
        chk("rsv err", err, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async busy", busy, 16'h0);
        chk("async inflight", inflight, 6'd0);
        chk("async err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post-rst stall", stall, 1'b0);
        chk("post-rst accept", issue_accept, 1'b1);
        @(posedge clk); #1;

        // Random traffic against the model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int r = 0; r < 16; r++) mcnt[r] = 0;
        merr = 1'b0;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 4)),
                  4'($urandom_range(0, 4)), 1'($urandom),
                  $urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, 4'($urandom_range(0, 3)));
            if (c % 97 == 50) begin
                wb_dest = 4'd15;
                issue_dest = 4'd15;
            end
            #1;
            acc = issue_valid && !model_stall();
            chk($sformatf("rnd%0d stall", c), stall, model_stall());
            chk($sformatf("rnd%0d accept", c), issue_accept, acc);
            @(posedge clk);
            #1;
            model_step(acc);
            chk($sformatf("rnd%0d busy", c), busy, mbusy());
            chk($sformatf("rnd%0d inflight", c), inflight, 6'(mtotal()));
            chk($sformatf("rnd%0d err", c), err, merr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
